// File: rtl/pmem_line_responder.sv
// Fixed-latency 256-bit line memory behind the cache's pmem_* port.
// Also flags initiators that drop or change a request before it completes.
module pmem_line_responder #(
  parameter int unsigned LATENCY    = 8,
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         pmem_read_i,
  input  logic         pmem_write_i,
  input  logic [31:0]  pmem_address_i,
  input  logic [255:0] pmem_wdata_i,
  output logic [255:0] pmem_rdata_o,
  output logic         pmem_resp_o,
  output logic         pmem_error_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [7:0] LOAD = 8'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic [31:0]           addr_q, addr_d;
  logic [255:0]          wdata_q, wdata_d;
  logic [255:0]          rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  req;
  logic                  violation;
  logic [INDEX_BITS-1:0] idx_in, idx_lat;

  logic [255:0] mem [2**INDEX_BITS];

  assign req     = pmem_read_i | pmem_write_i;
  assign idx_in  = pmem_address_i[5+INDEX_BITS-1:5];
  assign idx_lat = addr_q[5+INDEX_BITS-1:5];

  // While a request is outstanding the initiator must hold op and address steady.
  assign violation = (state_q != IDLE) &&
                     (!req || (pmem_read_i != rd_q) || (pmem_write_i != wr_q) ||
                      (pmem_address_i != addr_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q | violation;
    case (state_q)
      IDLE: begin
        if (req) begin
          rd_d    = pmem_read_i;
          wr_d    = pmem_write_i;
          addr_d  = pmem_address_i;
          wdata_d = pmem_wdata_i;
          cnt_d   = LOAD;
          if (pmem_read_i && pmem_write_i) err_d = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
            if (!pmem_write_i) rdata_d = mem[idx_in];
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        // rdata is registered, so it is loaded on the edge that enters RESP.
        if (cnt_q <= 8'd1) begin
          state_d = RESP;
          if (!wr_q) rdata_d = mem[idx_lat];
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 256'd0;
      rdata_q <= 256'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is never reset; a reset during RESP suppresses the commit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == RESP && wr_q) mem[idx_lat] <= wdata_q;
  end

  assign pmem_resp_o  = (state_q == RESP);
  assign pmem_rdata_o = rdata_q;
  assign pmem_error_o = err_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Scoreboarded bench for pmem_line_responder at LATENCY 8 (dut 0) and LATENCY 1 (dut 1).
module tb_pmem_line_responder;

  logic         clk;
  logic         rst;
  logic         rd    [2];
  logic         wr    [2];
  logic [31:0]  addr  [2];
  logic [255:0] wdata [2];
  logic [255:0] rdata [2];
  logic         resp  [2];
  logic         err   [2];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int           cycle;
    bit           chk;
    logic [255:0] data;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  localparam logic [255:0] D1 = {4{64'h0123456789ABCDEF}};
  localparam logic [255:0] DA = {8{32'hA5A5_0001}};
  localparam logic [255:0] DV = {8{32'h5555_0003}};
  localparam logic [255:0] DW = {8{32'h7777_0005}};
  localparam logic [255:0] DO = {8{32'hC0DE_0006}};
  localparam logic [255:0] DN = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] DL = {8{32'h1111_2222}};
  localparam logic [255:0] DZ = {8{32'h9999_0004}};

  pmem_line_responder #(.LATENCY(8), .INDEX_BITS(6)) u0 (
    .clk_i(clk), .rst_i(rst),
    .pmem_read_i(rd[0]), .pmem_write_i(wr[0]),
    .pmem_address_i(addr[0]), .pmem_wdata_i(wdata[0]),
    .pmem_rdata_o(rdata[0]), .pmem_resp_o(resp[0]), .pmem_error_o(err[0])
  );

  pmem_line_responder #(.LATENCY(1), .INDEX_BITS(6)) u1 (
    .clk_i(clk), .rst_i(rst),
    .pmem_read_i(rd[1]), .pmem_write_i(wr[1]),
    .pmem_address_i(addr[1]), .pmem_wdata_i(wdata[1]),
    .pmem_rdata_o(rdata[1]), .pmem_resp_o(resp[1]), .pmem_error_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the head of that DUT's queue.
  always @(negedge clk) begin
    exp_t e;
    if (resp[0] === 1'b1) begin
      if (sb0.size() == 0) checkOutput("dut0_unexpected_resp", 256'(cyc), 256'(-1));
      else begin
        e = sb0.pop_front();
        checkOutput("dut0_resp_cycle", 256'(cyc), 256'(e.cycle));
        if (e.chk) checkOutput("dut0_rdata", rdata[0], e.data);
      end
    end
    if (resp[1] === 1'b1) begin
      if (sb1.size() == 0) checkOutput("dut1_unexpected_resp", 256'(cyc), 256'(-1));
      else begin
        e = sb1.pop_front();
        checkOutput("dut1_resp_cycle", 256'(cyc), 256'(e.cycle));
        if (e.chk) checkOutput("dut1_rdata", rdata[1], e.data);
      end
    end
  end

  function automatic int latOf(input int d);
    return (d == 0) ? 8 : 1;
  endfunction

  task automatic pushExp(input int d, input int c, input bit chk, input logic [255:0] data);
    exp_t e;
    e.cycle = c;
    e.chk   = chk;
    e.data  = data;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Waits for a response pulse, then advances to just after the next rising edge.
  task automatic waitResp(input int d, output int seen);
    seen = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (resp[d] === 1'b1) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) begin
      total++;
      bad++;
      $display("[TB] FAIL dut%0d_resp_timeout: got none expected a pulse", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int d, input logic r, input logic w, input logic [31:0] a,
                               input logic [255:0] wd, input bit chk, input logic [255:0] expd,
                               input bit drop, output int seen);
    rd[d]    = r;
    wr[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    pushExp(d, cyc + latOf(d), chk, expd);
    waitResp(d, seen);
    if (drop) begin
      rd[d] = 1'b0;
      wr[d] = 1'b0;
    end
  endtask

  initial begin
    int r1, r2, c0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'd0; wdata[d] = 256'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_resp", 256'(resp[d]), 256'd0);
      checkOutput("reset_rdata", rdata[d], 256'd0);
      checkOutput("reset_error", 256'(err[d]), 256'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] write/read round trip, latency 8");
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0040, D1, 1'b0, 256'd0, 1'b1, r1);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0040, 256'd0, 1'b1, D1, 1'b1, r1);
    checkOutput("rt_error", 256'(err[0]), 256'd0);

    $display("[TB] aliasing");
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0820, DA, 1'b0, 256'd0, 1'b1, r1);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0020, 256'd0, 1'b1, DA, 1'b1, r1);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0024, 256'd0, 1'b1, DA, 1'b1, r1);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0060, DV, 1'b0, 256'd0, 1'b1, r1);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_00A0, DW, 1'b0, 256'd0, 1'b1, r1);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_00C0, DO, 1'b0, 256'd0, 1'b1, r1);
    checkOutput("rdata_held_over_writes", rdata[0], DA);

    $display("[TB] back-to-back, latency 8");
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0040, 256'd0, 1'b1, D1, 1'b0, r1);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_00C0, 256'd0, 1'b1, DO, 1'b1, r2);
    checkOutput("b2b_gap8", 256'(r2 - r1), 256'd9);

    $display("[TB] address change mid-request");
    rd[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0000_0060;
    c0 = cyc;
    pushExp(0, c0 + 8, 1'b1, DV);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    addr[0] = 32'h0000_00A0;
    @(negedge clk);
    checkOutput("viol_error_before", 256'(err[0]), 256'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("viol_error_after", 256'(err[0]), 256'd1);
    waitResp(0, r1);
    rd[0] = 1'b0;
    checkOutput("viol_error_sticky", 256'(err[0]), 256'd1);

    $display("[TB] reset during write, read held through reset");
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h0000_00C0; wdata[0] = DN;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    wr[0] = 1'b0;
    rd[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_rdata", rdata[0], 256'd0);
    checkOutput("rst_error", 256'(err[0]), 256'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pushExp(0, cyc + 8, 1'b1, DO);
    waitResp(0, r1);
    rd[0] = 1'b0;
    checkOutput("post_rst_error", 256'(err[0]), 256'd0);

    $display("[TB] latency 1");
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_0040, DL, 1'b0, 256'd0, 1'b1, r1);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0040, 256'd0, 1'b1, DL, 1'b0, r1);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0040, 256'd0, 1'b1, DL, 1'b1, r2);
    checkOutput("b2b_gap1", 256'(r2 - r1), 256'd2);
    checkOutput("l1_error_clean", 256'(err[1]), 256'd0);
    applyStimulus(1, 1'b1, 1'b1, 32'h0000_0080, DZ, 1'b0, 256'd0, 1'b1, r1);
    checkOutput("both_high_error", 256'(err[1]), 256'd1);
    checkOutput("both_high_rdata_kept", rdata[1], DL);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0080, 256'd0, 1'b1, DZ, 1'b1, r1);

    repeat (12) @(posedge clk);
    #1;
    checkOutput("sb0_drained", 256'(sb0.size()), 256'd0);
    checkOutput("sb1_drained", 256'(sb1.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
